// File: rtl/pgm_wr_if.sv
// Bundles the pgm_wr data, PHV, RAM-write, status and config signals.
// No logic inside; the slave modport is the pgm_wr view.
// The master modport is the view of whatever surrounds it.
interface pgm_wr_if;
    logic [1023:0] in_wr_phv;
    logic          in_wr_phv_wr;
    logic          out_wr_phv_alf;
    logic [133:0]  in_wr_data;
    logic          in_wr_data_wr;
    logic          in_wr_valid;
    logic          in_wr_valid_wr;
    logic          out_wr_alf;
    logic [1023:0] out_wr_phv;
    logic          out_wr_phv_wr;
    logic          in_wr_phv_alf;
    logic [133:0]  out_wr_data;
    logic          out_wr_data_wr;
    logic          out_wr_valid;
    logic          out_wr_valid_wr;
    logic          in_wr_alf;
    logic          wr2ram_wr_en;
    logic [143:0]  wr2ram_wdata;
    logic [6:0]    wr2ram_addr;
    logic          pgm_bypass_flag;
    logic          pgm_sent_start_flag;
    logic          pgm_sent_finish_flag;
    logic [133:0]  cin_wr_data;
    logic          cin_wr_data_wr;
    logic          cout_wr_ready;
    logic [133:0]  cout_wr_data;
    logic          cout_wr_data_wr;
    logic          cin_wr_ready;

    modport slave (
        input  in_wr_phv, in_wr_phv_wr, in_wr_data, in_wr_data_wr,
        input  in_wr_valid, in_wr_valid_wr, in_wr_phv_alf, in_wr_alf,
        input  cin_wr_data, cin_wr_data_wr, cin_wr_ready,
        output out_wr_phv_alf, out_wr_alf, out_wr_phv, out_wr_phv_wr,
        output out_wr_data, out_wr_data_wr, out_wr_valid, out_wr_valid_wr,
        output wr2ram_wr_en, wr2ram_wdata, wr2ram_addr,
        output pgm_bypass_flag, pgm_sent_start_flag, pgm_sent_finish_flag,
        output cout_wr_ready, cout_wr_data, cout_wr_data_wr
    );

    modport master (
        output in_wr_phv, in_wr_phv_wr, in_wr_data, in_wr_data_wr,
        output in_wr_valid, in_wr_valid_wr, in_wr_phv_alf, in_wr_alf,
        output cin_wr_data, cin_wr_data_wr, cin_wr_ready,
        input  out_wr_phv_alf, out_wr_alf, out_wr_phv, out_wr_phv_wr,
        input  out_wr_data, out_wr_data_wr, out_wr_valid, out_wr_valid_wr,
        input  wr2ram_wr_en, wr2ram_wdata, wr2ram_addr,
        input  pgm_bypass_flag, pgm_sent_start_flag, pgm_sent_finish_flag,
        input  cout_wr_ready, cout_wr_data, cout_wr_data_wr
    );
endinterface

// File: rtl/pgm_wr.sv
// Program writer: bypasses packets to pgm_rd, or captures one armed packet into program RAM.
// Latency: 1 cycle on every registered path (data, valid, PHV, RAM write, config echo).
// Backpressure: almost-full and config ready are passed straight through, combinationally.
module pgm_wr #(
    parameter logic [7:0]  MODULE_ID   = 8'd70,
    parameter logic [15:0] BASE_ADDR16 = 16'h0001
) (
    input  logic    clk,
    input  logic    rst_n,
    pgm_wr_if.slave bus
);
    typedef enum logic {BYPASS = 1'b0, CAPTURE = 1'b1} state_t;

    state_t     state;
    logic       arm;
    logic       in_flight;
    // One bit wider than the RAM address so bit 7 marks "RAM full".
    logic [7:0] wr_ptr;

    logic [1:0] dat_hdr;
    logic       is_head;
    logic       is_tail;
    logic       start_cap;
    logic       capturing;
    logic       cap_tail;
    logic       cfg_hit;
    logic       arm_set;
    logic       arm_clr;
    logic       unused_cfg_bits;

    // Header 00 is a single-flit packet, so it counts as both head and tail.
    assign dat_hdr   = bus.in_wr_data[133:132];
    assign is_head   = (dat_hdr == 2'b01) || (dat_hdr == 2'b00);
    assign is_tail   = (dat_hdr == 2'b10) || (dat_hdr == 2'b00);
    // A head only starts a capture when no bypassed packet is still open.
    assign start_cap = (state == BYPASS) && bus.in_wr_data_wr && is_head && arm && !in_flight;
    assign capturing = (state == CAPTURE) || start_cap;
    assign cap_tail  = capturing && bus.in_wr_data_wr && is_tail;

    assign cfg_hit = bus.cin_wr_data_wr
                  && (bus.cin_wr_data[133:132] == 2'b01)
                  && bus.cin_wr_data[127]
                  && (bus.cin_wr_data[126:124] == 3'b001)
                  && (bus.cin_wr_data[111:104] == MODULE_ID)
                  && (bus.cin_wr_data[95:80] == BASE_ADDR16);
    assign arm_set = cfg_hit && (bus.cin_wr_data[79:64] == 16'd1) && bus.cin_wr_data[32];
    assign arm_clr = cfg_hit && (bus.cin_wr_data[79:64] == 16'd2) && bus.cin_wr_data[32];

    assign unused_cfg_bits = ^{bus.cin_wr_data[131:128], bus.cin_wr_data[123:112],
                               bus.cin_wr_data[103:96], bus.cin_wr_data[63:33],
                               bus.cin_wr_data[31:0]};

    assign bus.cout_wr_ready  = bus.cin_wr_ready;
    assign bus.out_wr_alf     = bus.in_wr_alf;
    assign bus.out_wr_phv_alf = bus.in_wr_phv_alf;

    // Config chain echo and the arm register. The arm register is registered,
    // so a head flit in the same cycle as a config write sees the old value.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            bus.cout_wr_data    <= '0;
            bus.cout_wr_data_wr <= 1'b0;
            arm                 <= 1'b0;
        end else begin
            bus.cout_wr_data    <= bus.cin_wr_data;
            bus.cout_wr_data_wr <= bus.cin_wr_data_wr;
            if (arm_set) begin
                arm <= 1'b1;
            end else if (arm_clr || cap_tail) begin
                arm <= 1'b0;
            end
        end
    end

    // Data path FSM: forward in BYPASS, write flits to RAM in CAPTURE.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state                    <= BYPASS;
            in_flight                <= 1'b0;
            wr_ptr                   <= 8'd0;
            bus.out_wr_phv           <= '0;
            bus.out_wr_phv_wr        <= 1'b0;
            bus.out_wr_data          <= '0;
            bus.out_wr_data_wr       <= 1'b0;
            bus.out_wr_valid         <= 1'b0;
            bus.out_wr_valid_wr      <= 1'b0;
            bus.wr2ram_wr_en         <= 1'b0;
            bus.wr2ram_wdata         <= '0;
            bus.wr2ram_addr          <= 7'd0;
            bus.pgm_bypass_flag      <= 1'b1;
            bus.pgm_sent_start_flag  <= 1'b0;
            bus.pgm_sent_finish_flag <= 1'b0;
        end else begin
            bus.out_wr_phv           <= bus.in_wr_phv;
            bus.out_wr_phv_wr        <= bus.in_wr_phv_wr;
            bus.out_wr_data_wr       <= 1'b0;
            bus.out_wr_valid_wr      <= 1'b0;
            bus.wr2ram_wr_en         <= 1'b0;
            bus.pgm_sent_start_flag  <= 1'b0;
            bus.pgm_sent_finish_flag <= 1'b0;

            if (!capturing) begin
                bus.out_wr_data     <= bus.in_wr_data;
                bus.out_wr_data_wr  <= bus.in_wr_data_wr;
                bus.out_wr_valid    <= bus.in_wr_valid;
                bus.out_wr_valid_wr <= bus.in_wr_valid_wr;
                if (bus.in_wr_data_wr) begin
                    if (is_tail) begin
                        in_flight <= 1'b0;
                    end else if (is_head) begin
                        in_flight <= 1'b1;
                    end
                end
            end else if (bus.in_wr_data_wr) begin
                // Once the pointer reaches 128 flits are dropped until the tail.
                if (!wr_ptr[7]) begin
                    bus.wr2ram_wr_en <= 1'b1;
                    bus.wr2ram_wdata <= {10'b0, bus.in_wr_data};
                    bus.wr2ram_addr  <= wr_ptr[6:0];
                    wr_ptr           <= wr_ptr + 8'd1;
                end
                bus.pgm_sent_start_flag <= start_cap;
                if (is_tail) begin
                    state                    <= BYPASS;
                    wr_ptr                   <= 8'd0;
                    bus.pgm_sent_finish_flag <= 1'b1;
                    bus.pgm_bypass_flag      <= 1'b1;
                end else begin
                    state               <= CAPTURE;
                    bus.pgm_bypass_flag <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_pgm_wr.sv
// Bench for pgm_wr: a config/probe vector table plus hand sequences for the multi-cycle cases.
// Expected outputs are pushed with a due cycle when stimulus is driven.
// A negedge monitor pops and compares each queue whenever the DUT strobes.
module tb_pgm_wr;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pgm_wr_if bus();

    pgm_wr #(.MODULE_ID(8'd70), .BASE_ADDR16(16'h0001)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [6:0]   addr;
        logic [133:0] dat;
        logic         we;
        logic         st;
        logic         fin;
        int           due;
    } ram_exp_t;
    typedef struct { logic [133:0] dat; int due; } dat_exp_t;
    typedef struct { logic [1023:0] phv; int due; } phv_exp_t;
    typedef struct { logic vld; int due; } vld_exp_t;
    typedef struct {
        bit           pre_arm;
        logic [133:0] cfg;
        bit           exp_cap;
        string        name;
    } vec_t;

    ram_exp_t ram_q[$];
    dat_exp_t fwd_q[$];
    dat_exp_t cfg_q[$];
    phv_exp_t phv_q[$];
    vld_exp_t vld_q[$];

    task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [133:0] mk_cfg(input logic [1:0] hdr, input logic vld,
                                            input logic [2:0] typ, input logic [7:0] dst,
                                            input logic [15:0] base, input logic [15:0] lo,
                                            input logic d32);
        return {hdr, 4'b0000, vld, typ, 12'h000, dst, 8'd61, base, lo, {31{d32}}, d32, 32'h0};
    endfunction

    // Advance one cycle; strobes are single-cycle unless re-driven.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.in_wr_data_wr  = 1'b0;
        bus.in_wr_valid_wr = 1'b0;
        bus.in_wr_phv_wr   = 1'b0;
        bus.cin_wr_data_wr = 1'b0;
    endtask

    task automatic drive_cfg(input logic [133:0] f);
        bus.cin_wr_data    = f;
        bus.cin_wr_data_wr = 1'b1;
        cfg_q.push_back('{dat: f, due: cyc + 1});
    endtask

    task automatic send_cfg(input logic [133:0] f);
        drive_cfg(f);
        tick();
    endtask

    // Drive flit i of an n-flit packet and record where it is expected to land.
    task automatic drive_flit(input int i, input int n, input bit cap);
        logic [1:0]    h;
        logic [133:0]  f;
        logic [1023:0] p;
        if (n == 1)          h = 2'b00;
        else if (i == 0)     h = 2'b01;
        else if (i == n - 1) h = 2'b10;
        else                 h = 2'b11;
        f = {h, $urandom(), $urandom(), $urandom(), 4'h0, i[31:0]};
        bus.in_wr_data    = f;
        bus.in_wr_data_wr = 1'b1;
        if (cap) begin
            if (i < 128)
                ram_q.push_back('{addr: i[6:0], dat: f, we: 1'b1, st: (i == 0),
                                  fin: (i == n - 1), due: cyc + 1});
            else if (i == n - 1)
                ram_q.push_back('{addr: 7'd0, dat: '0, we: 1'b0, st: 1'b0,
                                  fin: 1'b1, due: cyc + 1});
        end else begin
            fwd_q.push_back('{dat: f, due: cyc + 1});
        end
        if (i == 0) begin
            for (int k = 0; k < 32; k++) p[k*32 +: 32] = $urandom();
            bus.in_wr_phv    = p;
            bus.in_wr_phv_wr = 1'b1;
            phv_q.push_back('{phv: p, due: cyc + 1});
        end
        if (i == n - 1) begin
            bus.in_wr_valid    = 1'b1;
            bus.in_wr_valid_wr = 1'b1;
            if (!cap) vld_q.push_back('{vld: 1'b1, due: cyc + 1});
        end
    endtask

    task automatic send_pkt(input int n, input bit cap);
        for (int i = 0; i < n; i++) begin
            drive_flit(i, n, cap);
            tick();
        end
        tick();
    endtask

    ram_exp_t re;
    dat_exp_t de;
    phv_exp_t pe;
    vld_exp_t ve;

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            if (bus.wr2ram_wr_en || bus.pgm_sent_start_flag || bus.pgm_sent_finish_flag) begin
                chk("ram_event_expected", ram_q.size() != 0, 1'b1);
                if (ram_q.size() != 0) begin
                    re = ram_q.pop_front();
                    chk("ram_due", cyc, re.due);
                    chk("ram_we", bus.wr2ram_wr_en, re.we);
                    if (re.we) begin
                        chk("ram_addr", bus.wr2ram_addr, re.addr);
                        chk("ram_wdata", bus.wr2ram_wdata, {10'b0, re.dat});
                    end
                    chk("ram_start", bus.pgm_sent_start_flag, re.st);
                    chk("ram_finish", bus.pgm_sent_finish_flag, re.fin);
                end
            end
            if (bus.out_wr_data_wr) begin
                chk("fwd_expected", fwd_q.size() != 0, 1'b1);
                if (fwd_q.size() != 0) begin
                    de = fwd_q.pop_front();
                    chk("fwd_due", cyc, de.due);
                    chk("fwd_data", bus.out_wr_data, de.dat);
                end
            end
            if (bus.out_wr_valid_wr) begin
                chk("vld_expected", vld_q.size() != 0, 1'b1);
                if (vld_q.size() != 0) begin
                    ve = vld_q.pop_front();
                    chk("vld_due", cyc, ve.due);
                    chk("vld_value", bus.out_wr_valid, ve.vld);
                end
            end
            if (bus.out_wr_phv_wr) begin
                chk("phv_expected", phv_q.size() != 0, 1'b1);
                if (phv_q.size() != 0) begin
                    pe = phv_q.pop_front();
                    chk("phv_due", cyc, pe.due);
                    chk("phv_value", bus.out_wr_phv === pe.phv, 1'b1);
                end
            end
            if (bus.cout_wr_data_wr) begin
                chk("cfg_expected", cfg_q.size() != 0, 1'b1);
                if (cfg_q.size() != 0) begin
                    de = cfg_q.pop_front();
                    chk("cfg_due", cyc, de.due);
                    chk("cfg_data", bus.cout_wr_data, de.dat);
                end
            end
        end
    end

    logic [133:0] SET, CLR;
    vec_t vecs[11];

    initial begin
        bus.in_wr_phv = '0;    bus.in_wr_phv_wr = 1'b0;
        bus.in_wr_data = '0;   bus.in_wr_data_wr = 1'b0;
        bus.in_wr_valid = 1'b0; bus.in_wr_valid_wr = 1'b0;
        bus.in_wr_phv_alf = 1'b0; bus.in_wr_alf = 1'b0;
        bus.cin_wr_data = '0;  bus.cin_wr_data_wr = 1'b0;
        bus.cin_wr_ready = 1'b0;

        SET = mk_cfg(2'b01, 1'b1, 3'b001, 8'd70, 16'h0001, 16'd1, 1'b1);
        CLR = mk_cfg(2'b01, 1'b1, 3'b001, 8'd70, 16'h0001, 16'd2, 1'b1);
        vecs[0]  = '{1'b0, SET, 1'b1, "set_arm"};
        vecs[1]  = '{1'b1, CLR, 1'b0, "clear_arm"};
        vecs[2]  = '{1'b0, mk_cfg(2'b01, 1'b1, 3'b001, 8'd71, 16'h0001, 16'd1, 1'b1), 1'b0, "dst71"};
        vecs[3]  = '{1'b0, mk_cfg(2'b01, 1'b1, 3'b001, 8'd70, 16'h0001, 16'd3, 1'b1), 1'b0, "addr3"};
        vecs[4]  = '{1'b0, mk_cfg(2'b01, 1'b1, 3'b001, 8'd70, 16'h0001, 16'd1, 1'b0), 1'b0, "set_d32_0"};
        vecs[5]  = '{1'b0, mk_cfg(2'b01, 1'b1, 3'b010, 8'd70, 16'h0001, 16'd1, 1'b1), 1'b0, "type010"};
        vecs[6]  = '{1'b0, mk_cfg(2'b01, 1'b1, 3'b001, 8'd70, 16'h0002, 16'd1, 1'b1), 1'b0, "base2"};
        vecs[7]  = '{1'b0, mk_cfg(2'b11, 1'b1, 3'b001, 8'd70, 16'h0001, 16'd1, 1'b1), 1'b0, "hdr11"};
        vecs[8]  = '{1'b0, mk_cfg(2'b01, 1'b0, 3'b001, 8'd70, 16'h0001, 16'd1, 1'b1), 1'b0, "valid0"};
        vecs[9]  = '{1'b1, mk_cfg(2'b01, 1'b1, 3'b001, 8'd70, 16'h0001, 16'd2, 1'b0), 1'b1, "clr_d32_0"};
        vecs[10] = '{1'b1, mk_cfg(2'b01, 1'b1, 3'b001, 8'd70, 16'h0001, 16'd3, 1'b1), 1'b1, "keep_addr3"};

        // Reset state
        tick(); tick(); tick();
        chk("rst_bypass_flag", bus.pgm_bypass_flag, 1'b1);
        chk("rst_ram_we", bus.wr2ram_wr_en, 1'b0);
        chk("rst_data_wr", bus.out_wr_data_wr, 1'b0);
        chk("rst_valid_wr", bus.out_wr_valid_wr, 1'b0);
        chk("rst_phv_wr", bus.out_wr_phv_wr, 1'b0);
        chk("rst_cout_wr", bus.cout_wr_data_wr, 1'b0);
        chk("rst_start", bus.pgm_sent_start_flag, 1'b0);
        chk("rst_finish", bus.pgm_sent_finish_flag, 1'b0);
        rst_n = 1'b0;
        tick();

        // Combinational pass-throughs
        bus.in_wr_alf = 1'b1; bus.in_wr_phv_alf = 1'b0; bus.cin_wr_ready = 1'b1; #1;
        chk("alf_hi", bus.out_wr_alf, 1'b1);
        chk("phv_alf_lo", bus.out_wr_phv_alf, 1'b0);
        chk("ready_hi", bus.cout_wr_ready, 1'b1);
        bus.in_wr_alf = 1'b0; bus.in_wr_phv_alf = 1'b1; bus.cin_wr_ready = 1'b0; #1;
        chk("alf_lo", bus.out_wr_alf, 1'b0);
        chk("phv_alf_hi", bus.out_wr_phv_alf, 1'b1);
        chk("ready_lo", bus.cout_wr_ready, 1'b0);
        bus.in_wr_phv_alf = 1'b0; bus.cin_wr_ready = 1'b1;
        tick();

        // Config decode table, each probed by a 3-flit packet
        for (int v = 0; v < 11; v++) begin
            if (vecs[v].pre_arm) send_cfg(SET);
            send_cfg(vecs[v].cfg);
            send_pkt(3, vecs[v].exp_cap);
            tick();
        end

        // Bypass flag across a capture
        send_cfg(SET);
        chk("flag_before", bus.pgm_bypass_flag, 1'b1);
        drive_flit(0, 3, 1'b1); tick();
        chk("flag_head", bus.pgm_bypass_flag, 1'b0);
        drive_flit(1, 3, 1'b1); tick();
        chk("flag_mid", bus.pgm_bypass_flag, 1'b0);
        drive_flit(2, 3, 1'b1); tick();
        chk("flag_tail", bus.pgm_bypass_flag, 1'b1);
        tick();

        // 130-flit packet: addresses 0..127, then drops, finish on the tail
        send_cfg(SET);
        send_pkt(130, 1'b1);

        // Single-flit packet is head and tail; arm is consumed
        send_cfg(SET);
        send_pkt(1, 1'b1);
        send_pkt(3, 1'b0);

        // Arming during a bypassed packet leaves that packet bypassing
        drive_flit(0, 3, 1'b0); tick();
        drive_flit(1, 3, 1'b0); drive_cfg(SET); tick();
        drive_flit(2, 3, 1'b0); tick();
        tick();
        send_pkt(3, 1'b1);

        // Config set in the same cycle as a head: old arm (0) applies
        drive_flit(0, 3, 1'b0); drive_cfg(SET); tick();
        drive_flit(1, 3, 1'b0); tick();
        drive_flit(2, 3, 1'b0); tick();
        tick();
        send_pkt(3, 1'b1);

        // Clear during capture does not abort the packet
        send_cfg(SET);
        drive_flit(0, 3, 1'b1); tick();
        drive_flit(1, 3, 1'b1); drive_cfg(CLR); tick();
        drive_flit(2, 3, 1'b1); tick();
        tick();
        send_pkt(3, 1'b0);

        // Reset mid-capture: no finish, arm gone
        send_cfg(SET);
        drive_flit(0, 3, 1'b1); tick();
        drive_flit(1, 3, 1'b1); tick();
        tick();
        rst_n = 1'b1;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        chk("post_rst_flag", bus.pgm_bypass_flag, 1'b1);
        send_pkt(3, 1'b0);

        tick(); tick(); tick();
        chk("ram_q_empty", ram_q.size(), 0);
        chk("fwd_q_empty", fwd_q.size(), 0);
        chk("cfg_q_empty", cfg_q.size(), 0);
        chk("phv_q_empty", phv_q.size(), 0);
        chk("vld_q_empty", vld_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pgm_wr.md
PGM_WR -- requirements
Module: pgm_wr

Interface
REQ-001 Parameter MODULE_ID, default 8'd70, is the config-packet destination ID this block answers to.
REQ-002 Parameter BASE_ADDR16, default 16'h0001, is the register-block select, matched against cfg address bits [31:16].
REQ-003 clk  in  1  single clock; all logic is rising-edge.
REQ-004 rst_n  in  1  synchronous, active-high reset (port name kept per codebase; asserted = 1).
REQ-005 in_wr_phv  in  1024  PHV from upstream.
REQ-006 in_wr_phv_wr  in  1  PHV strobe.
REQ-007 out_wr_phv_alf  out  1  PHV almost-full to upstream.
REQ-008 in_wr_data  in  134  packet flit; [133:132] header (01 head, 11 middle, 10 tail).
REQ-009 in_wr_data_wr  in  1  flit strobe.
REQ-010 in_wr_valid, in_wr_valid_wr  in  1 each  packet-valid flag and its strobe.
REQ-011 out_wr_alf  out  1  data almost-full to upstream.
REQ-012 out_wr_phv / out_wr_phv_wr  out  1024/1  PHV to pgm_rd.
REQ-013 in_wr_phv_alf  in  1  PHV almost-full from pgm_rd.
REQ-014 out_wr_data / out_wr_data_wr  out  134/1  flit to pgm_rd.
REQ-015 out_wr_valid / out_wr_valid_wr  out  1/1  valid flag to pgm_rd.
REQ-016 in_wr_alf  in  1  data almost-full from pgm_rd.
REQ-017 wr2ram_wr_en / wr2ram_wdata / wr2ram_addr  out  1/144/7  program-RAM write port.
REQ-018 pgm_bypass_flag / pgm_sent_start_flag / pgm_sent_finish_flag  out  1 each  status to pgm_rd.
REQ-019 cin_wr_data / cin_wr_data_wr  in  134/1  config flits from DMA.
REQ-020 cout_wr_ready  out  1  config ready to DMA.
REQ-021 cout_wr_data / cout_wr_data_wr  out  134/1  config flits to next module.
REQ-022 cin_wr_ready  in  1  ready from next module.

Function
REQ-023 Config flit fields: [133:128] header, [127] valid, [126:124] type (3'b001 = write), [111:104] dst ID, [103:96] src ID, [95:64] address, [63:0] data.
REQ-024 Every config flit, on cin_wr_data_wr=1, appears unchanged on cout_wr_data with cout_wr_data_wr=1 one cycle later; cout_wr_ready = cin_wr_ready, combinational.
REQ-025 A flit is a register write when all hold: header [133:132]=01, valid=1, type=001, dst=MODULE_ID and addr[31:16]=BASE_ADDR16.
REQ-026 Write to addr[15:0]=1 with data[32]=1 sets the arm bit; write to addr[15:0]=2 with data[32]=1 clears it; other addresses and data[32]=0 have no effect.
REQ-027 The write takes effect on the cycle after the flit.
REQ-028 Data path states: BYPASS (default) and CAPTURE.
REQ-029 BYPASS: every input data, valid and PHV strobe and its value is registered to the matching output with 1-cycle latency; out_wr_alf = in_wr_alf and out_wr_phv_alf = in_wr_phv_alf, combinational.
REQ-030 BYPASS -> CAPTURE: on a head flit (header 01) with arm=1; a packet already in flight keeps bypassing until its tail.
REQ-031 CAPTURE: each flit is written to RAM (wr2ram_wr_en=1, wdata={10'b0, flit}), address starting at 0 for the head and +1 per flit; the flit is not forwarded.
REQ-032 In CAPTURE, in_wr_valid_wr events are suppressed; PHV is always forwarded in either state.
REQ-033 Writes stop after address 127 with no wrap; later flits are dropped until the tail.
REQ-034 On the tail flit (header 10): return to BYPASS and clear arm.
REQ-035 A single-flit packet with arm=1 is treated as both head and tail.
REQ-036 pgm_bypass_flag = 0 in CAPTURE, else 1.
REQ-037 pgm_sent_start_flag pulses 1 cycle with the head RAM write; pgm_sent_finish_flag pulses 1 cycle with the tail write or tail drop.
REQ-038 A clear-arm write during CAPTURE does not abort the packet.
REQ-039 Simultaneous cfg write and data head flit: the arm value before the write is used.

Reset
REQ-040 While rst_n=1 at a clock edge: state=BYPASS, arm=0, RAM address=0, pgm_bypass_flag=1, and all other registered outputs and strobes are 0.
REQ-041 Reset mid-capture abandons the packet with no finish pulse.

Verification
REQ-042 Reset -> pgm_bypass_flag=1, all strobes 0, wr2ram_wr_en=0.
REQ-043 Config head {6'b010000,1,3'b001,12'b0,8'd70,8'd61,32'h00010001,32'hffffffff,32'h0} -> echoed on cout one cycle later; arm=1.
REQ-044 Then the same flit with addr 32'h00010002 -> arm=0; the next 3-flit packet bypasses with 1-cycle latency and no RAM write.
REQ-045 Armed, then a 3-flit packet -> RAM writes to addresses 0,1,2; start pulse on address 0; finish pulse on address 2; out_wr_data_wr stays 0; bypass flag 0 then 1.
REQ-046 Armed, then a 130-flit packet -> writes to addresses 0..127 only; finish pulses on the tail; no wrap.
REQ-047 Config flit with dst=8'd71 -> forwarded with no register change.
